redirect_ctrl: RTL
==================

# redirect_ctrl

Sequencer that sits behind the branch unit in the execute stage. It turns a resolved taken branch or jump into a fetch redirect, flushes wrong-path stages, and holds the redirect until fetch accepts it. It then masks in-flight fetch returns for a programmable kill window. It also raises the instruction-address-misaligned exception on bad targets and keeps resolve/taken performance counters.

## Interface

Parameters:
- KILL_CYCLES, 2: cycles of wrong-path masking after redirect acceptance; 0 allowed.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- exe_v_i  in  1  valid instruction in execute this cycle.
- bu_en_i  in  1  instruction uses the branch unit.
- branch_v_i  in  1  branch unit says taken (jal/jalr always taken).
- pc_nxt_i  in  XLEN  branch unit target.
- trap_flush_i  in  1  trap/CSR flush; overrides everything.
- redirect_rdy_i  in  1  fetch accepts redirect this cycle.
- redirect_v_o  out  1  redirect request valid.
- redirect_pc_o  out  XLEN  redirect target; stable while redirect_v_o=1.
- flush_o  out  1  kill IF/DEC contents and fetch returns.
- stall_exe_o  out  1  hold execute while a redirect is pending.
- exc_v_o  out  1  misaligned-target exception, one-cycle pulse.
- exc_tval_o  out  XLEN  faulting target; valid with exc_v_o.
- resolve_cnt_o  out  CNT_W  branch-unit instructions accepted.
- taken_cnt_o  out  CNT_W  redirects issued.

## Operation

- A resolve is the condition exe_v_i & bu_en_i. A resolve is accepted only in IDLE with trap_flush_i=0. Resolves in any other state are wrong-path and are ignored, including for the counters.
- States: IDLE, REDIRECT, KILL.
- IDLE, accepted resolve with branch_v_i=0: resolve_cnt += 1; no state change.
- IDLE, accepted resolve with branch_v_i=1 and pc_nxt_i[1:0]!=0:
  - resolve_cnt += 1.
  - exc_v_o=1 and exc_tval_o=pc_nxt_i on the next cycle.
  - No redirect, no taken count; remain in IDLE.
- IDLE, accepted resolve with branch_v_i=1 and aligned target:
  - Register target into redirect_pc_o.
  - resolve_cnt += 1, taken_cnt += 1.
  - Go to REDIRECT.
- REDIRECT: redirect_v_o=1, flush_o=1, stall_exe_o=1.
  - If redirect_rdy_i=1: go to KILL with the kill counter loaded to KILL_CYCLES-1, or go to IDLE if KILL_CYCLES=0.
  - Otherwise hold; redirect_pc_o must not change.
- KILL: flush_o=1, redirect_v_o=0, stall_exe_o=0. Decrement the counter; go to IDLE when it reaches 0.
- trap_flush_i=1 in any state:
  - Next state IDLE; pending redirect dropped; kill counter cleared.
  - Same-cycle resolve ignored; counters unchanged.
  - exc_v_o suppressed.
- Counters wrap modulo 2^CNT_W with no saturation.

## Timing

- Reset values: state IDLE, and every output 0 (redirect_v_o, redirect_pc_o, flush_o, stall_exe_o, exc_v_o, exc_tval_o, both counters). Reset mid-REDIRECT or mid-KILL aborts immediately and asynchronously.
- Resolve sampled at edge N → redirect_v_o, flush_o and stall_exe_o high from cycle N+1. All outputs are state-decoded; there is no combinational input→output path.
- Redirect handshake: the transfer happens on the edge where redirect_v_o & redirect_rdy_i. redirect_rdy_i already high in N+1 → one-cycle REDIRECT.
- KILL lasts exactly KILL_CYCLES cycles, so flush_o is high for (REDIRECT cycles + KILL_CYCLES). An IDLE resolve is accepted in the first IDLE cycle after KILL.
- exc_v_o is high for exactly cycle N+1.
- Counters update on edge N and are visible in N+1.
- Back-to-back taken branches: the second is wrong-path, arrives while not IDLE, and is ignored.

## Structure

- riscv package holds XLEN (existing) and the new redirect_state_t enum (IDLE, REDIRECT, KILL).
- One sub-module is natural: perf_counter, a CNT_W-wide counter with enable and async active-low clear. Instantiate it twice.
- FSM, kill counter and target register live in redirect_ctrl.

## Test plan

- Not-taken: resolve with branch_v_i=0, pc_nxt_i=0x100 → no redirect, no flush; resolve_cnt=1, taken_cnt=0.
- Taken, immediate accept: target 0x2000, redirect_rdy_i=1 → redirect_v_o high 1 cycle with pc 0x2000; flush_o high 3 cycles (KILL_CYCLES=2); taken_cnt=1.
- Backpressure: target 0x3004, redirect_rdy_i low 4 cycles then high → redirect_pc_o stable at 0x3004 for 5 cycles. During those cycles a second resolve (target 0x4000) is ignored, resolve_cnt stays 1.
- Misaligned: jalr target 0x1002 → exc_v_o for 1 cycle, exc_tval_o=0x1002, no redirect_v_o; resolve_cnt=1, taken_cnt=0.
- Trap override: trap_flush_i=1 in the second REDIRECT cycle → IDLE next cycle, redirect_v_o=0, flush_o=0. Trap simultaneous with a resolve → resolve not counted.
- Reset mid-KILL and counter wrap: reset_n low → all outputs 0 immediately. Preload resolve_cnt to 2^CNT_W−1 via a run with CNT_W=4 (15 resolves), then one more resolve → 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural width and the branch-redirect sequencer state.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        KILL     = 2'd2
    } redirect_state_t;

    // Instructions are 32-bit only, so any target not on a 4-byte boundary faults.
    function automatic logic target_misaligned(input logic [XLEN-1:0] target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W, cleared by async reset.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/redirect_ctrl.sv
// Turns resolved taken branches into a held fetch redirect, flushes wrong-path work for a
// kill window afterwards, flags misaligned targets and counts resolves/redirects.
module redirect_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned KILL_CYCLES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             exe_v_i,
    input  logic             bu_en_i,
    input  logic             branch_v_i,
    input  logic [XLEN-1:0]  pc_nxt_i,
    input  logic             trap_flush_i,
    input  logic             redirect_rdy_i,
    output logic             redirect_v_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             stall_exe_o,
    output logic             exc_v_o,
    output logic [XLEN-1:0]  exc_tval_o,
    output logic [CNT_W-1:0] resolve_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam int unsigned KW = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
    localparam logic [KW-1:0] KillLoad = (KILL_CYCLES == 0) ? '0 : KW'(KILL_CYCLES - 1);

    redirect_state_t state_q;
    logic [KW-1:0]   kill_cnt_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            redirect_v_q;
    logic            flush_q;
    logic            stall_q;
    logic            exc_v_q;
    logic [XLEN-1:0] exc_tval_q;

    logic resolve_acc;
    logic target_bad;
    logic taken_acc;

    // Resolves outside IDLE belong to the wrong path and never touch state or counters.
    always_comb begin
        resolve_acc = (state_q == IDLE) && !trap_flush_i && exe_v_i && bu_en_i;
        target_bad  = target_misaligned(pc_nxt_i);
        taken_acc   = resolve_acc && branch_v_i && !target_bad;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            kill_cnt_q    <= '0;
            redirect_pc_q <= '0;
            redirect_v_q  <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            exc_v_q       <= 1'b0;
            exc_tval_q    <= '0;
        end else begin
            exc_v_q <= 1'b0;
            if (trap_flush_i) begin
                state_q      <= IDLE;
                kill_cnt_q   <= '0;
                redirect_v_q <= 1'b0;
                flush_q      <= 1'b0;
                stall_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (resolve_acc && branch_v_i) begin
                            if (target_bad) begin
                                exc_v_q    <= 1'b1;
                                exc_tval_q <= pc_nxt_i;
                            end else begin
                                redirect_pc_q <= pc_nxt_i;
                                state_q       <= REDIRECT;
                                redirect_v_q  <= 1'b1;
                                flush_q       <= 1'b1;
                                stall_q       <= 1'b1;
                            end
                        end
                    end
                    REDIRECT: begin
                        if (redirect_rdy_i) begin
                            redirect_v_q <= 1'b0;
                            stall_q      <= 1'b0;
                            if (KILL_CYCLES == 0) begin
                                state_q <= IDLE;
                                flush_q <= 1'b0;
                            end else begin
                                state_q    <= KILL;
                                kill_cnt_q <= KillLoad;
                            end
                        end
                    end
                    KILL: begin
                        if (kill_cnt_q == '0) begin
                            state_q <= IDLE;
                            flush_q <= 1'b0;
                        end else begin
                            kill_cnt_q <= kill_cnt_q - KW'(1);
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        redirect_v_q <= 1'b0;
                        flush_q      <= 1'b0;
                        stall_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign redirect_v_o  = redirect_v_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = flush_q;
    assign stall_exe_o   = stall_q;
    assign exc_v_o       = exc_v_q;
    assign exc_tval_o    = exc_tval_q;

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_resolve_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (resolve_acc),
        .cnt_o  (resolve_cnt_o)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_taken_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (taken_acc),
        .cnt_o  (taken_cnt_o)
    );

endmodule
